// File: rtl/serial_add_seq.sv
// Multi-byte add/subtract sequencer driving one 8-bit adder slice.
// Operands are consumed LSB byte first; the carry is held between bytes.
module serial_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   op_a,
    input  logic [8*NBYTES-1:0]   op_b,
    input  logic                  op_sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   result,
    output logic                  carry_out,
    output logic                  overflow,
    output logic                  busy
);

    localparam int IW = $clog2(NBYTES);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                   state;
    state_t                   state_nx;
    logic [IW-1:0]            idx;
    logic                     cy;
    logic                     sub_q;
    logic [NBYTES-1:0][7:0]   a_q;
    logic [NBYTES-1:0][7:0]   b_q;
    logic [NBYTES-1:0][7:0]   res_q;
    logic [7:0]               a_byte;
    logic [7:0]               b_byte;
    logic [8:0]               s9;
    logic                     last;
    logic                     ovf_nx;

    // Byte slice: B is inverted for subtract, the +1 comes from the seeded carry.
    always_comb begin
        a_byte = a_q[idx];
        b_byte = b_q[idx] ^ {8{sub_q}};
        s9     = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, cy};
        last   = (idx == IW'(NBYTES - 1));
        ovf_nx = (a_byte[7] ~^ b_byte[7]) & (s9[7] ^ a_byte[7]);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, per-byte accumulation and final flag capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            cy        <= 1'b0;
            sub_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_q   <= op_a;
            b_q   <= op_b;
            sub_q <= op_sub;
            idx   <= '0;
            cy    <= op_sub;
        end else if (state == RUN) begin
            res_q[idx] <= s9[7:0];
            cy         <= s9[8];
            if (last) begin
                carry_out <= s9[8];
                overflow  <= ovf_nx;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign result    = res_q;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq: 4-byte main instance plus a 2-byte
// instance for the short-width latency case.
module tb_serial_add_seq;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        carry_out;
    logic        overflow;
    logic        busy;

    logic        v2_in;
    logic        r2_in;
    logic [15:0] a2;
    logic [15:0] b2;
    logic        s2;
    logic        v2_out;
    logic [15:0] res2;
    logic        co2;
    logic        ov2;
    logic        busy2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_add_seq #(.NBYTES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    serial_add_seq #(.NBYTES(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v2_in),
        .in_ready  (r2_in),
        .op_a      (a2),
        .op_b      (b2),
        .op_sub    (s2),
        .out_valid (v2_out),
        .out_ready (out_ready),
        .result    (res2),
        .carry_out (co2),
        .overflow  (ov2),
        .busy      (busy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request on the 4-byte instance and wait for out_valid.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic sub, output int lat);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        op_sub   = sub;
        tick();
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    logic [31:0] held_res;
    logic        held_co;
    logic        held_ov;
    logic [31:0] bb_a   [3];
    logic [31:0] bb_b   [3];
    logic        bb_s   [3];
    logic [31:0] bb_res [3];
    int          bb_t   [3];

    initial begin
        int lat;
        int k;
        int nres;
        logic acc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_sub    = 1'b0;
        out_ready = 1'b1;
        v2_in     = 1'b0;
        a2        = '0;
        b2        = '0;
        s2        = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_busy",      busy,      0);
        chk("rst_result",    result,    0);
        chk("rst_carry",     carry_out, 0);
        chk("rst_ovf",       overflow,  0);

        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
        chk("add_wrap_lat",   lat,       4);
        chk("add_wrap_res",   result,    32'h0000_0000);
        chk("add_wrap_co",    carry_out, 1);
        chk("add_wrap_ov",    overflow,  0);
        chk("done_in_ready",  in_ready,  0);
        chk("done_busy",      busy,      1);
        tick();
        chk("idle_in_ready",  in_ready,  1);
        chk("idle_out_valid", out_valid, 0);

        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, lat);
        chk("sub5_7_res", result,    32'hFFFF_FFFE);
        chk("sub5_7_co",  carry_out, 0);
        chk("sub5_7_ov",  overflow,  0);
        tick();

        run_op(32'h0000_0007, 32'h0000_0005, 1'b1, lat);
        chk("sub7_5_res", result,    32'h0000_0002);
        chk("sub7_5_co",  carry_out, 1);
        chk("sub7_5_ov",  overflow,  0);
        tick();

        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
        chk("addov_res", result,    32'h8000_0000);
        chk("addov_co",  carry_out, 0);
        chk("addov_ov",  overflow,  1);
        tick();

        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, lat);
        chk("subov_res", result,    32'h7FFF_FFFF);
        chk("subov_co",  carry_out, 1);
        chk("subov_ov",  overflow,  1);
        tick();

        out_ready = 1'b0;
        run_op(32'h0000_1234, 32'h0000_0F0F, 1'b0, lat);
        chk("bp_valid", out_valid, 1);
        held_res = result;
        held_co  = carry_out;
        held_ov  = overflow;
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            op_a     = 32'hFFFF_FFFF;
            op_b     = 32'hFFFF_FFFF;
            op_sub   = c[1];
            tick();
            chk("bp_res",      result,    32'h0000_2143);
            chk("bp_hold_res", result,    held_res);
            chk("bp_hold_co",  carry_out, held_co);
            chk("bp_hold_ov",  overflow,  held_ov);
            chk("bp_in_ready", in_ready,  0);
            chk("bp_valid_hi", out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_rel_valid", out_valid, 0);
        chk("bp_rel_ready", in_ready,  1);
        chk("bp_keep_res",  result,    32'h0000_2143);

        in_valid = 1'b1;
        op_a     = 32'h1234_5678;
        op_b     = 32'h1111_1111;
        op_sub   = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_res",   result,    0);
        chk("mrst_co",    carry_out, 0);
        chk("mrst_ov",    overflow,  0);
        chk("mrst_ready", in_ready,  1);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("mrst_no_valid", out_valid, 0);
        end
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, lat);
        chk("fresh_lat", lat,    4);
        chk("fresh_res", result, 32'h2345_6789);
        tick();

        bb_a[0] = 32'h0000_0001; bb_b[0] = 32'h0000_0002; bb_s[0] = 1'b0;
        bb_a[1] = 32'h1000_0000; bb_b[1] = 32'h0FFF_FFFF; bb_s[1] = 1'b0;
        bb_a[2] = 32'h0000_0100; bb_b[2] = 32'h0000_0001; bb_s[2] = 1'b1;
        k        = 0;
        nres     = 0;
        in_valid = 1'b1;
        op_a     = bb_a[0];
        op_b     = bb_b[0];
        op_sub   = bb_s[0];
        for (int c = 0; c < 40 && nres < 3; c++) begin
            acc = in_ready && in_valid;
            tick();
            if (acc) begin
                k++;
                if (k < 3) begin
                    op_a   = bb_a[k];
                    op_b   = bb_b[k];
                    op_sub = bb_s[k];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                bb_res[nres] = result;
                bb_t[nres]   = c;
                nres++;
            end
        end
        in_valid = 1'b0;
        chk("bb_count", nres, 3);
        if (nres == 3) begin
            chk("bb_res0", bb_res[0], 32'h0000_0003);
            chk("bb_res1", bb_res[1], 32'h1FFF_FFFF);
            chk("bb_res2", bb_res[2], 32'h0000_00FF);
            chk("bb_gap1", bb_t[1] - bb_t[0], 6);
            chk("bb_gap2", bb_t[2] - bb_t[1], 6);
        end
        tick();

        v2_in = 1'b1;
        a2    = 16'hFFFF;
        b2    = 16'h0001;
        s2    = 1'b0;
        tick();
        v2_in = 1'b0;
        lat   = 0;
        while (!v2_out && lat < 20) begin
            tick();
            lat++;
        end
        chk("n2_lat", lat,  2);
        chk("n2_res", res2, 16'h0000);
        chk("n2_co",  co2,  1);
        chk("n2_ov",  ov2,  0);
        tick();
        chk("n2_idle", r2_in, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
